// File: rtl/comb_vector_driver.sv
// comb_vector_driver: applies an incrementing stimulus sequence to a combinational DUT
// and compacts its sampled responses into a rotate-XOR signature.
module comb_vector_driver #(
    parameter int SIZE   = 4,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               done_ack,
    input  logic [CNT_W-1:0]   num_vectors,
    input  logic [3*SIZE-1:0]  seed,
    output logic [SIZE-1:0]    src1,
    output logic [SIZE-1:0]    src2,
    output logic [SIZE-1:0]    src3,
    input  logic [SIZE-1:0]    res1,
    input  logic [SIZE-1:0]    res2,
    input  logic [SIZE-1:0]    res3,
    input  logic [SIZE-1:0]    res4,
    input  logic [SIZE-1:0]    res5,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   vec_count,
    output logic [5*SIZE-1:0]  signature
);
    localparam int W_W = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam logic [W_W-1:0] W_LAST = W_W'(SETTLE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [3*SIZE-1:0]   stim_q, stim_d;
    logic [W_W-1:0]      w_q, w_d;
    logic [CNT_W-1:0]    nv_q, nv_d, cnt_q, cnt_d;
    logic [5*SIZE-1:0]   sig_q, sig_d, resp;

    assign resp      = {res5, res4, res3, res2, res1};
    assign {src3, src2, src1} = stim_q;
    assign busy      = state_q == ST_SETTLE;
    assign done      = state_q == ST_DONE;
    assign vec_count = cnt_q;
    assign signature = sig_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            stim_q  <= '0;
            w_q     <= '0;
            nv_q    <= '0;
            cnt_q   <= '0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            w_q     <= w_d;
            nv_q    <= nv_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
        end
    end

    // abort takes priority over the sample edge, so an aborted vector never reaches the signature
    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        w_d     = w_q;
        nv_d    = nv_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        case (state_q)
            ST_IDLE: if (start) begin
                nv_d  = num_vectors;
                sig_d = '0;
                cnt_d = '0;
                if (num_vectors == '0) begin
                    state_d = ST_DONE;
                end else begin
                    stim_d  = seed;
                    w_d     = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: if (abort) begin
                state_d = ST_IDLE;
            end else if (w_q != W_LAST) begin
                w_d = w_q + 1'b1;
            end else begin
                sig_d = {sig_q[5*SIZE-2:0], sig_q[5*SIZE-1]} ^ resp;
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == nv_q) begin
                    state_d = ST_DONE;
                end else begin
                    stim_d = stim_q + 1'b1;
                    w_d    = '0;
                end
            end
            ST_DONE: if (done_ack) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_comb_vector_driver.sv
// tb_comb_vector_driver: directed and randomized runs of comb_vector_driver against a
// fake combinational DUT whose outputs are corrupted until each vector has settled.
module tb_comb_vector_driver;
    localparam int SIZE = 2, CNT_W = 8, SETTLE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n = 1'b0, start = 1'b0, abort = 1'b0, done_ack = 1'b0;
    logic [CNT_W-1:0] num_vectors = '0;
    logic [5:0]       seed = '0;
    logic [1:0]       src1, src2, src3, res1, res2, res3, res4, res5;
    logic             busy, done;
    logic [CNT_W-1:0] vec_count;
    logic [9:0]       signature;

    int         errors = 0, checks = 0;
    int         age = 100;
    logic [5:0] last_src = '0, exp_src = '0;

    comb_vector_driver #(.SIZE(SIZE), .CNT_W(CNT_W), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .done_ack(done_ack),
        .num_vectors(num_vectors), .seed(seed),
        .src1(src1), .src2(src2), .src3(src3),
        .res1(res1), .res2(res2), .res3(res3), .res4(res4), .res5(res5),
        .busy(busy), .done(done), .vec_count(vec_count), .signature(signature)
    );

    function automatic logic [9:0] resp_of(input logic [5:0] v);
        logic [1:0] s1, s2, s3, r1, r2, r3, r4, r5;
        s1 = v[1:0]; s2 = v[3:2]; s3 = v[5:4];
        r1 = s1 + s2; r2 = s2 ^ s3; r3 = s1 & s3; r4 = ~s1; r5 = s3 - s2;
        return {r5, r4, r3, r2, r1};
    endfunction

    // Vectors younger than SETTLE-1 full cycles produce inverted (unsettled) results
    always @(negedge clk) begin
        age      <= ({src3, src2, src1} !== last_src) ? 0 : age + 1;
        last_src <= {src3, src2, src1};
    end
    assign {res5, res4, res3, res2, res1} = resp_of({src3, src2, src1}) ^ ((age >= SETTLE - 1) ? 10'h000 : 10'h3FF);

    function automatic logic [9:0] sig_model(input logic [5:0] s, input int n);
        logic [9:0] sig;
        logic [5:0] v;
        sig = '0;
        for (int i = 0; i < n; i++) begin
            v   = s + 6'(i);
            sig = {sig[8:0], sig[9]} ^ resp_of(v);
        end
        return sig;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_run(input logic [5:0] s, input int n, input bit noise);
        int cyc;
        logic [5:0] e;
        @(negedge clk);
        start = 1'b1; seed = s; num_vectors = CNT_W'(n);
        @(negedge clk);
        start = 1'b0; seed = 6'($urandom); num_vectors = CNT_W'($urandom);
        cyc = 0;
        while (busy && cyc < n * SETTLE + 10) begin
            e = s + 6'(cyc / SETTLE);
            check("src_step", {src3, src2, src1}, e);
            cyc++;
            if (noise) begin
                start = 1'($urandom); seed = 6'($urandom); num_vectors = CNT_W'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_cycles", cyc, n * SETTLE);
        if (n > 0) exp_src = s + 6'(n - 1);
        check("done", {done, busy}, 2'b10);
        check("vec_count", vec_count, n);
        check("signature", signature, sig_model(s, n));
        check("src_final", {src3, src2, src1}, exp_src);
        repeat (2) begin
            if (noise) begin start = 1'b1; abort = 1'b1; end
            @(negedge clk);
        end
        start = 1'b0; abort = 1'b0;
        check("done_hold", {done, busy, vec_count}, {2'b10, CNT_W'(n)});
        done_ack = 1'b1;
        @(negedge clk);
        done_ack = 1'b0;
        check("done_ack", {done, busy}, 2'b00);
        check("sig_hold", signature, sig_model(s, n));
    endtask

    initial begin
        logic [5:0] s;
        repeat (2) @(negedge clk);
        check("rst_src", {src3, src2, src1}, 6'h00);
        check("rst_flags", {busy, done}, 2'b00);
        check("rst_cnt", vec_count, 0);
        check("rst_sig", signature, 0);
        rst_n = 1'b1;

        do_run(6'h05, 2, 1'b0);
        do_run(6'h3F, 2, 1'b0);
        do_run(6'($urandom), 0, 1'b0);

        s = 6'($urandom);
        @(negedge clk);
        start = 1'b1; seed = s; num_vectors = 8'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (3 * SETTLE - 1) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        exp_src = s + 6'd2;
        check("abort_flags", {busy, done}, 2'b00);
        check("abort_cnt", vec_count, 2);
        check("abort_sig", signature, sig_model(s, 2));
        check("abort_src", {src3, src2, src1}, exp_src);
        abort = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        check("idle_abort", {busy, done, vec_count, signature}, {2'b00, CNT_W'(2), sig_model(s, 2)});
        do_run(6'($urandom), 4, 1'b0);

        @(negedge clk);
        start = 1'b1; seed = 6'($urandom); num_vectors = 8'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0; start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0; exp_src = '0;
        check("midrst_outs", {src3, src2, src1, busy, done, vec_count, signature}, '0);
        @(negedge clk);
        check("midrst_idle", {busy, done}, 2'b00);
        do_run(6'($urandom), 3, 1'b0);

        for (int k = 0; k < 6; k++) do_run(6'($urandom), int'($urandom_range(1, 20)), 1'b1);
        do_run(6'($urandom), 255, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
